color_frame_parser: RTL and testbench
=====================================

COLOR_FRAME_PARSER -- requirements
Module: color_frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hAA, frame header value.
REQ-002 Parameter TIMEOUT_CYC, default 166660, max idle clocks between bytes inside a frame (about 2 characters at 1200 baud, 10 MHz).
REQ-003 clk  input  1  single system clock, 10 MHz nominal, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid in that cycle.
REQ-007 red, green, blue  output  8 each  latched colour duty values.
REQ-008 frame_ok  output  1  one-cycle pulse when a valid frame is committed.
REQ-009 frame_err  output  1  one-cycle pulse on checksum failure or timeout.
REQ-010 busy  output  1  high while a frame is in progress (state not IDLE).
REQ-011 err_cnt  output  8  count of frame_err pulses, saturating at 8'hFF.

Function
REQ-012 Frame format, in order: SYNC_BYTE, R, G, B, CHK; CHK = R xor G xor B.
REQ-013 FSM states: IDLE, GET_R, GET_G, GET_B, GET_CHK; state advances only on a cycle with rx_valid=1.
REQ-014 IDLE: rx_valid with rx_data==SYNC_BYTE goes to GET_R; any other byte is discarded, with no error pulse.
REQ-015 GET_R, GET_G, GET_B: the byte is stored in a shadow register; the next state is GET_G, GET_B, GET_CHK respectively.
REQ-016 A SYNC_BYTE value received in a data state is payload data, not a resync.
REQ-017 GET_CHK: if rx_data equals the xor of the shadow registers, red/green/blue load the shadow values and frame_ok=1 on the next clock edge (1-cycle latency); the state returns to IDLE.
REQ-018 GET_CHK mismatch: frame_err=1 on the next edge, red/green/blue are unchanged, and the state returns to IDLE.
REQ-019 Timeout counter: cleared on every rx_valid, and held at 0 in IDLE.
REQ-020 Timeout counter increments every clock in the non-IDLE states.
REQ-021 When the timeout counter reaches TIMEOUT_CYC-1 with no rx_valid in that cycle, the state returns to IDLE, frame_err pulses, and outputs are unchanged.
REQ-022 If rx_valid coincides with the timeout cycle, the byte is processed normally and no timeout occurs.
REQ-023 frame_ok and frame_err are never high in the same cycle, and each is high for exactly 1 cycle per event.
REQ-024 err_cnt increments on each frame_err pulse and holds at 8'hFF.
REQ-025 Timeout counter width is ceil(log2(TIMEOUT_CYC)) bits; it does not wrap within a frame.
REQ-026 A back-to-back frame is accepted: a SYNC_BYTE arriving the cycle after the CHK byte starts a new frame.

Reset
REQ-027 Reset asserted forces state IDLE, red/green/blue=8'h00, frame_ok=0, frame_err=0, busy=0, err_cnt=0, shadow registers 0, timeout counter 0, all asynchronously.
REQ-028 Reset asserted mid-frame discards the partial frame, with no error pulse.
REQ-029 The first frame after reset deassertion is parsed normally.

Verification
REQ-030 Frame AA,12,34,56,70 as strobes 10 clocks apart.
- Required: red=12, green=34, blue=56 one cycle after the CHK strobe.
- Required: frame_ok pulses once, err_cnt=0.
REQ-031 Frame AA,01,02,03,FF (bad CHK, correct is 00).
- Required: frame_err pulses once, err_cnt=1.
- Required: RGB keeps its prior values.
REQ-032 Bytes 55,00,AA,AA,AA,AA,AA.
- Required: 55 and 00 are ignored.
- Required: frame R=AA, G=AA, B=AA, CHK=AA is accepted, so red/green/blue=AA and frame_ok pulses.
REQ-033 AA,10 then silence for TIMEOUT_CYC clocks.
- Required: frame_err pulses exactly TIMEOUT_CYC-1 clocks after the 10 strobe, and busy falls.
- Required: a later AA,01,01,01,01 is accepted.
REQ-034 Reset pulsed after AA,20,30.
- Required: outputs are zero, busy=0, no frame_err.
- Required: the next full frame AA,05,06,07,04 gives RGB=05,06,07.
REQ-035 256+ bad-checksum frames.
- Required: err_cnt saturates at FF.
- Required: with rx_valid on the exact timeout cycle, the byte is accepted and there is no timeout error.

Source files
------------

// File: rtl/color_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : color_frame_parser
//  Purpose  : Parses 5-byte colour frames (SYNC, R, G, B, CHK) from a UART
//             byte stream and latches the RGB duty values on a good checksum.
//             CHK = R ^ G ^ B.  An idle gap inside a frame aborts it.
//  Ports    : clk        - system clock, rising edge
//             reset      - asynchronous active-high reset
//             rx_data    - received byte
//             rx_valid   - one-cycle strobe qualifying rx_data
//             red/green/blue - latched colour duty values
//             frame_ok   - one-cycle pulse when a frame is committed
//             frame_err  - one-cycle pulse on checksum failure or timeout
//             busy       - high while a frame is in progress
//             err_cnt    - saturating count of frame_err pulses
//  Revision : 1.0  initial release
// ============================================================================
module color_frame_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         TIMEOUT_CYC = 166660
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  // The timeout fires on the edge at which the idle counter would reach
  // TIMEOUT_CYC-1, so the error pulse appears TIMEOUT_CYC-1 clocks after the
  // last accepted byte.
  localparam logic [CW-1:0] c_TLAST = CW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_R   = 3'd1,
    S_GET_G   = 3'd2,
    S_GET_B   = 3'd3,
    S_GET_CHK = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_tcnt;
  logic [CW-1:0]   w_tcnt_nxt;
  logic [7:0]      r_shr, r_shg, r_shb;
  logic [7:0]      r_red, r_green, r_blue;
  logic            r_ok, r_err;
  logic [7:0]      r_err_cnt;
  logic            w_ld_r, w_ld_g, w_ld_b;
  logic            w_commit;
  logic            w_ok_nxt, w_err_nxt;
  logic            w_timeout;
  logic [7:0]      w_chk;

  assign w_chk     = r_shr ^ r_shg ^ r_shb;
  assign w_timeout = (r_state != S_IDLE) && !rx_valid && (r_tcnt == c_TLAST);

  always_comb begin
    w_state_nxt = r_state;
    w_ld_r      = 1'b0;
    w_ld_g      = 1'b0;
    w_ld_b      = 1'b0;
    w_commit    = 1'b0;
    w_ok_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) w_state_nxt = S_GET_R;
      end
      S_GET_R: begin
        if (rx_valid) begin
          w_ld_r      = 1'b1;
          w_state_nxt = S_GET_G;
        end
      end
      S_GET_G: begin
        if (rx_valid) begin
          w_ld_g      = 1'b1;
          w_state_nxt = S_GET_B;
        end
      end
      S_GET_B: begin
        if (rx_valid) begin
          w_ld_b      = 1'b1;
          w_state_nxt = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (rx_valid) begin
          if (rx_data == w_chk) begin
            w_commit = 1'b1;
            w_ok_nxt = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // w_timeout already excludes rx_valid cycles, so a byte landing on the
    // timeout cycle is processed above and never aborted here.
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_err_nxt   = 1'b1;
    end
  end

  always_comb begin
    w_tcnt_nxt = r_tcnt + CW'(1);
    if (rx_valid || (r_state == S_IDLE) || w_timeout) w_tcnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_shr     <= 8'h00;
      r_shg     <= 8'h00;
      r_shb     <= 8'h00;
      r_red     <= 8'h00;
      r_green   <= 8'h00;
      r_blue    <= 8'h00;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      if (w_ld_r) r_shr <= rx_data;
      if (w_ld_g) r_shg <= rx_data;
      if (w_ld_b) r_shb <= rx_data;
      if (w_commit) begin
        r_red   <= r_shr;
        r_green <= r_shg;
        r_blue  <= r_shb;
      end
      if (w_err_nxt && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign busy      = (r_state != S_IDLE);
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_color_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_color_frame_parser
//  Purpose  : Directed self-checking bench for color_frame_parser.  Inputs are
//             driven and outputs sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_color_frame_parser;

  localparam int T = 20;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] red, green, blue;
  logic       frame_ok, frame_err, busy;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  color_frame_parser #(
    .SYNC_BYTE  (8'hAA),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .frame_ok (frame_ok),
    .frame_err(frame_err),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge and
  // the task returns at the following falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_rgb(input string tag, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
    check({tag, "_red"},   red,   r);
    check({tag, "_green"}, green, g);
    check({tag, "_blue"},  blue,  b);
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    check_rgb("rst", 8'h00, 8'h00, 8'h00);
    check("rst_ok",   frame_ok,  1'b0);
    check("rst_err",  frame_err, 1'b0);
    check("rst_busy", busy,      1'b0);
    check("rst_cnt",  err_cnt,   8'h00);
    reset = 1'b0;
    idle(1);

    // Good frame, strobes 10 clocks apart
    send(8'hAA); idle(9);
    send(8'h12); idle(9);
    send(8'h34); idle(9);
    send(8'h56); idle(9);
    check("f1_busy", busy, 1'b1);
    send(8'h70);
    check("f1_ok",  frame_ok,  1'b1);
    check("f1_err", frame_err, 1'b0);
    check_rgb("f1", 8'h12, 8'h34, 8'h56);
    check("f1_cnt", err_cnt, 8'h00);
    idle(1);
    check("f1_ok_once", frame_ok, 1'b0);

    // Bad checksum
    send(8'hAA); send(8'h01); send(8'h02); send(8'h03); send(8'hFF);
    check("f2_err", frame_err, 1'b1);
    check("f2_ok",  frame_ok,  1'b0);
    check_rgb("f2", 8'h12, 8'h34, 8'h56);
    check("f2_cnt", err_cnt, 8'h01);
    idle(1);
    check("f2_err_once", frame_err, 1'b0);

    // Garbage before sync, then SYNC values used as payload
    send(8'h55); send(8'h00);
    check("f3_busy_idle", busy, 1'b0);
    check("f3_noerr", frame_err, 1'b0);
    send(8'hAA); send(8'hAA); send(8'hAA); send(8'hAA);
    check("f3_busy", busy, 1'b1);
    send(8'hAA);
    check("f3_ok", frame_ok, 1'b1);
    check_rgb("f3", 8'hAA, 8'hAA, 8'hAA);
    check("f3_cnt", err_cnt, 8'h01);

    // Timeout inside a frame
    idle(1);
    send(8'hAA); send(8'h10);
    idle(T - 2);
    check("to_early_err", frame_err, 1'b0);
    check("to_early_busy", busy, 1'b1);
    idle(1);
    check("to_err",  frame_err, 1'b1);
    check("to_busy", busy,      1'b0);
    check("to_cnt",  err_cnt,   8'h02);
    check_rgb("to", 8'hAA, 8'hAA, 8'hAA);
    idle(1);
    check("to_err_once", frame_err, 1'b0);
    send(8'hAA); send(8'h01); send(8'h01); send(8'h01); send(8'h01);
    check("to_next_ok", frame_ok, 1'b1);
    check_rgb("to_next", 8'h01, 8'h01, 8'h01);

    // Reset mid-frame
    idle(1);
    send(8'hAA); send(8'h20); send(8'h30);
    reset = 1'b1;
    #1;
    check_rgb("mr", 8'h00, 8'h00, 8'h00);
    check("mr_busy", busy,    1'b0);
    check("mr_cnt",  err_cnt, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    check("mr_noerr", frame_err, 1'b0);
    idle(1);
    check("mr_noerr2", frame_err, 1'b0);
    send(8'hAA); send(8'h05); send(8'h06); send(8'h07); send(8'h04);
    check("mr_ok", frame_ok, 1'b1);
    check_rgb("mr_next", 8'h05, 8'h06, 8'h07);

    // Bytes landing exactly on the timeout cycle are accepted
    idle(1);
    send(8'hAA); idle(T - 2);
    send(8'h11); idle(T - 2);
    send(8'h22); idle(T - 2);
    send(8'h44); idle(T - 2);
    check("edge_busy", busy, 1'b1);
    check("edge_noerr", frame_err, 1'b0);
    send(8'h77);
    check("edge_ok",  frame_ok,  1'b1);
    check("edge_err", frame_err, 1'b0);
    check("edge_cnt", err_cnt,   8'h00);
    check_rgb("edge", 8'h11, 8'h22, 8'h44);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) begin
      send(8'hAA); send(8'h01); send(8'h02); send(8'h03); send(8'hFF);
      if (i == 253) check("sat_fe", err_cnt, 8'hFE);
    end
    check("sat_err", frame_err, 1'b1);
    check("sat_ff",  err_cnt,   8'hFF);
    check_rgb("sat", 8'h11, 8'h22, 8'h44);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
